fsm_pump_rotator: RTL and testbench
===================================

# fsm_pump_rotator

Parametrised N-pump sump controller with lead-pump rotation. Reads a thermometer-coded level-sensor bus and switches on as many pumps as sensors asserted, starting from a rotating lead pump. It detects illegal sensor codes and forces a safe all-pumps-on fault mode. It is the generalised successor of the two-pump `fsm_sequence` alternator and sits between the sensor input synchroniser and the pump driver outputs.

## Interface
- `N_PUMPS`, 2: number of pumps and of level sensors; legal range 2..8.
- `MIN_ON_CYCLES`, 4: minimum pump on-time in clock cycles; legal range ≥1; used only with `PUMP_MIN_ON_EN`.
- `clock` in 1: single system clock; all state updates on its rising edge.
- `reset` in 1: synchronous, active-high reset.
- `sensors` in N_PUMPS: level sensors, thermometer code, bit 0 = lowest.
- `pumps` out N_PUMPS: pump enables, registered.
- `lead` out clog2(N_PUMPS): index of the current lead pump.
- `demand` out clog2(N_PUMPS+1): number of pumps requested, i.e. count of set sensor bits; 0 when the code is illegal.
- `state` out 2: current FSM state.
- `fault` out 1: high while in FAULT.

## Operation
- States: IDLE=2'b00, RUN=2'b01, FAULT=2'b10.
- Legal code: `sensors` is of the form 0…01…1, including all-zero. Any other pattern is illegal (e.g. 2'b10).
- Demand mask: for a legal code with count k, set bits at indices (lead+j) mod N_PUMPS for j = 0..k-1. Index arithmetic wraps N_PUMPS-1 → 0.
- IDLE:
  - k=0: stay, pumps=0.
  - k>0: go to RUN, pumps=mask.
  - illegal code: go to FAULT.
- RUN:
  - pumps=mask while k>0.
  - When next pumps is all-zero: go to IDLE and lead ← (lead+1) mod N_PUMPS.
  - illegal code: go to FAULT.
- FAULT:
  - pumps=all-ones, fault=1, lead frozen.
  - On the first legal code: go to RUN with pumps=mask if k>0, else IDLE with pumps=0. Lead is not advanced on either exit.
- Simultaneous conditions: illegal code takes priority over every other transition. Reset takes priority over everything.
- Reset (also mid-operation): on the next edge pumps=0, lead=0, demand=0, state=IDLE, fault=0, all timers=0.

## Timing
- All outputs are registered. Sensors sampled at edge t appear on `pumps`, `state`, `lead` and `fault` after edge t, giving 1-cycle latency.
- `demand` is registered together with pumps and reflects the same sample.
- The lead update and the RUN→IDLE transition occur on the same edge.
- No handshake: sensors are sampled every cycle and must already be synchronised.

## Configuration
- `PUMP_MIN_ON_EN` defined:
  - Each pump has a timer of width clog2(MIN_ON_CYCLES).
  - Every 0→1 pump transition (including fault entry) loads MIN_ON_CYCLES-1.
  - While timer≠0 the pump stays forced on and the timer decrements.
  - pumps[i] = mask[i] | (timer[i]≠0). Result: every turn-on lasts at least MIN_ON_CYCLES cycles.
  - RUN→IDLE and lead advance wait until all pumps are off.
- Not defined: no timers; pumps follow the mask immediately; MIN_ON_CYCLES is ignored.

## Structure
- Shared include/package `fsm_pump_pkg`: state encodings (IDLE/RUN/FAULT), state width, N_PUMPS legal range check.
- One sub-module, `sensor_thermo_decode`: combinational legality check plus popcount. Outputs `valid` and `count`.
- Top module holds the FSM, lead register, mask rotation and the optional timers.

## Test plan
- Reset: reset=1 for one edge with sensors=00 → pumps=00, lead=0, state=IDLE, fault=0, demand=0.
- Rotation, N_PUMPS=2: sensors 01 → pumps=01, RUN. Then 11 → pumps=11. Then 01 → pumps=01. Then 00 → pumps=00, IDLE, lead=1. Then 01 → pumps=10.
- Fault: from RUN with lead=1, sensors=10 → pumps=11, fault=1, state=FAULT, lead=1. Then sensors=01 → pumps=10, fault=0, RUN, lead=1.
- Wrap, N_PUMPS=4: drive lead to 3, then sensors=0011 → pumps=1001, demand=2. Then 0000 → lead=0.
- Reset mid-run: sensors=11 in RUN, reset=1 for one edge → pumps=00, lead=0, IDLE, even though sensors stay at 11. The following edge with reset=0 → pumps=11.
- `PUMP_MIN_ON_EN`, MIN_ON_CYCLES=4: sensors=01 for one cycle, then 00 → pump0 high for exactly 4 cycles; lead advances on the falling edge of pump0. Without the macro: pump0 high for 1 cycle.

Source files
------------

// File: rtl/fsm_pump_pkg.sv
// Shared definitions for the rotating-lead sump pump controller:
// state encodings, legal pump-count range and small elaboration helpers.
package fsm_pump_pkg;

   localparam int STATE_W     = 2;
   localparam int N_PUMPS_MIN = 2;
   localparam int N_PUMPS_MAX = 8;

   typedef enum logic [STATE_W-1:0] {
      IDLE  = 2'b00,
      RUN   = 2'b01,
      FAULT = 2'b10
   } state_t;

   function automatic bit n_pumps_legal(input int n);
      return (n >= N_PUMPS_MIN) && (n <= N_PUMPS_MAX);
   endfunction

   // Keeps zero-width vectors out of the design when a clog2 collapses to 0.
   function automatic int width_min1(input int w);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/fsm_pump_rotator_if.sv
// Sensor-in / pump-out bundle of the pump rotator; the slave side is the
// controller, the master side is whatever drives the sensors.
interface fsm_pump_rotator_if
   import fsm_pump_pkg::*;
#(
   parameter int N_PUMPS = 2
);
   localparam int LEAD_W   = $clog2(N_PUMPS);
   localparam int DEMAND_W = $clog2(N_PUMPS + 1);

   logic [N_PUMPS-1:0]  sensors;
   logic [N_PUMPS-1:0]  pumps;
   logic [LEAD_W-1:0]   lead;
   logic [DEMAND_W-1:0] demand;
   logic [STATE_W-1:0]  state;
   logic                fault;

   modport master (output sensors, input pumps, input lead, input demand, input state, input fault);
   modport slave  (input sensors, output pumps, output lead, output demand, output state, output fault);

endinterface

// File: rtl/fsm_pump_rotator_decode.sv
// Combinational check that the level sensors form a thermometer code
// (0...01...1, all-zero included) plus a count of the asserted sensors.
module sensor_thermo_decode #(
   parameter int N_PUMPS = 2,
   parameter int COUNT_W = $clog2(N_PUMPS + 1)
) (
   input  logic [N_PUMPS-1:0] sensors,
   output logic               valid,
   output logic [COUNT_W-1:0] count
);

   logic [N_PUMPS-1:0] plus_one;

   // A thermometer code plus one is a single power of two (or wraps to zero),
   // so it shares no set bit with the original code.
   always_comb begin
      plus_one = sensors + {{(N_PUMPS-1){1'b0}}, 1'b1};
      valid    = ((sensors & plus_one) == '0);
      count    = '0;
      for (int i = 0; i < N_PUMPS; i++) begin
         count = count + COUNT_W'(sensors[i]);
      end
   end

endmodule

// File: rtl/fsm_pump_rotator.sv
// N-pump sump controller with rotating lead pump and all-on fault mode.
// Optional build macro PUMP_MIN_ON_EN adds per-pump minimum on-time timers.
module fsm_pump_rotator
   import fsm_pump_pkg::*;
#(
   parameter int N_PUMPS       = 2,
   parameter int MIN_ON_CYCLES = 4
) (
   input  logic                 clock,
   input  logic                 reset,
   fsm_pump_rotator_if.slave    bus
);

   localparam int LEAD_W   = $clog2(N_PUMPS);
   localparam int DEMAND_W = $clog2(N_PUMPS + 1);

   if (!n_pumps_legal(N_PUMPS) || (MIN_ON_CYCLES < 1)) begin : g_param_check
      $error("fsm_pump_rotator: N_PUMPS must be 2..8 and MIN_ON_CYCLES >= 1");
   end

   state_t                state_q;
   logic [N_PUMPS-1:0]    pumps_q;
   logic [LEAD_W-1:0]     lead_q;
   logic [DEMAND_W-1:0]   demand_q;
   logic                  fault_q;

   logic                  code_valid;
   logic [DEMAND_W-1:0]   code_count;
   logic [2*N_PUMPS-1:0]  doubled;
   logic [N_PUMPS-1:0]    mask;
   logic [N_PUMPS-1:0]    hold;
   logic [N_PUMPS-1:0]    pumps_d;
   logic [LEAD_W-1:0]     lead_next;

   sensor_thermo_decode #(
      .N_PUMPS (N_PUMPS),
      .COUNT_W (DEMAND_W)
   ) u_decode (
      .sensors (bus.sensors),
      .valid   (code_valid),
      .count   (code_count)
   );

   // A legal code is already the unrotated mask, so rotating it left by the
   // lead index places its k ones at lead, lead+1, ... with wraparound.
   always_comb begin
      doubled   = {bus.sensors, bus.sensors} << lead_q;
      mask      = doubled[2*N_PUMPS-1:N_PUMPS];
      pumps_d   = code_valid ? (mask | hold) : '1;
      lead_next = (lead_q == LEAD_W'(N_PUMPS - 1)) ? '0 : lead_q + LEAD_W'(1);
   end

`ifdef PUMP_MIN_ON_EN
   localparam int TIMER_W = width_min1($clog2(MIN_ON_CYCLES));

   logic [TIMER_W-1:0] timer_q [N_PUMPS];

   always_comb begin
      for (int i = 0; i < N_PUMPS; i++) begin
         hold[i] = (timer_q[i] != '0);
      end
   end

   // Every turn-on (fault entry included) arms the timer; the pump is then
   // held on until the timer drains, giving MIN_ON_CYCLES of on-time.
   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < N_PUMPS; i++) begin
            timer_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < N_PUMPS; i++) begin
            if (pumps_d[i] && !pumps_q[i]) begin
               timer_q[i] <= TIMER_W'(MIN_ON_CYCLES - 1);
            end else if (hold[i]) begin
               timer_q[i] <= timer_q[i] - TIMER_W'(1);
            end
         end
      end
   end
`else
   assign hold = '0;
`endif

   // Illegal codes win over everything but reset; otherwise the state simply
   // follows whether any pump stays on, and the lead moves only when a run ends.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q  <= IDLE;
         pumps_q  <= '0;
         lead_q   <= '0;
         demand_q <= '0;
         fault_q  <= 1'b0;
      end else if (!code_valid) begin
         state_q  <= FAULT;
         pumps_q  <= '1;
         demand_q <= '0;
         fault_q  <= 1'b1;
      end else begin
         pumps_q  <= pumps_d;
         demand_q <= code_count;
         fault_q  <= 1'b0;
         state_q  <= (|pumps_d) ? RUN : IDLE;
         if ((state_q == RUN) && !(|pumps_d)) begin
            lead_q <= lead_next;
         end
      end
   end

   assign bus.pumps  = pumps_q;
   assign bus.lead   = lead_q;
   assign bus.demand = demand_q;
   assign bus.state  = state_q;
   assign bus.fault  = fault_q;

endmodule

// File: tb/tb_fsm_pump_rotator.sv
// Bench for fsm_pump_rotator at N_PUMPS=2 and 4 against a behavioural model;
// honours PUMP_MIN_ON_EN when the build defines it.
module tb_fsm_pump_rotator;

   localparam int MIN_ON = 4;

   logic clock = 1'b0;
   logic reset = 1'b1;

   int checks   = 0;
   int failures = 0;

   int         np [2] = '{2, 4};
   logic [7:0] m_pumps [2];
   int         m_lead  [2];
   int         m_state [2];
   int         m_demand[2];
   int         m_rem   [2][8];

   fsm_pump_rotator_if #(.N_PUMPS(2)) bus2 ();
   fsm_pump_rotator_if #(.N_PUMPS(4)) bus4 ();

   fsm_pump_rotator #(.N_PUMPS(2), .MIN_ON_CYCLES(MIN_ON)) dut2 (
      .clock (clock),
      .reset (reset),
      .bus   (bus2)
   );

   fsm_pump_rotator #(.N_PUMPS(4), .MIN_ON_CYCLES(MIN_ON)) dut4 (
      .clock (clock),
      .reset (reset),
      .bus   (bus4)
   );

   always #5 clock = ~clock;

   // Model: pumps on = the k pumps starting at lead (plus any still owed
   // on-time), all pumps on for a non-thermometer code.
   task automatic modelStep(input int d, input logic [7:0] s, input bit r);
      int         n;
      int         k;
      int         ns;
      logic [7:0] full;
      logic [7:0] nxt;
      n    = np[d];
      full = (8'd1 << n) - 8'd1;
      if (r) begin
         m_pumps[d]  = '0;
         m_lead[d]   = 0;
         m_state[d]  = 0;
         m_demand[d] = 0;
         for (int i = 0; i < 8; i++) m_rem[d][i] = 0;
         return;
      end
      k = $countones(s);
      if (s != ((8'd1 << k) - 8'd1)) begin
         nxt         = full;
         ns          = 2;
         m_demand[d] = 0;
      end else begin
         nxt = '0;
         for (int j = 0; j < k; j++) nxt[(m_lead[d] + j) % n] = 1'b1;
`ifdef PUMP_MIN_ON_EN
         for (int i = 0; i < n; i++) if (m_rem[d][i] > 0) nxt[i] = 1'b1;
`endif
         ns = (nxt != 0) ? 1 : 0;
         if (m_state[d] == 1 && ns == 0) m_lead[d] = (m_lead[d] + 1) % n;
         m_demand[d] = k;
      end
`ifdef PUMP_MIN_ON_EN
      for (int i = 0; i < n; i++) begin
         if (nxt[i] && !m_pumps[d][i]) m_rem[d][i] = MIN_ON - 1;
         else if (m_rem[d][i] > 0)     m_rem[d][i] = m_rem[d][i] - 1;
      end
`endif
      m_pumps[d] = nxt;
      m_state[d] = ns;
   endtask

   task automatic applyStimulus(input logic [1:0] a, input logic [3:0] b, input bit r);
      bus2.sensors = a;
      bus4.sensors = b;
      reset        = r;
      @(posedge clock);
      modelStep(0, {6'd0, a}, r);
      modelStep(1, {4'd0, b}, r);
      #1;
   endtask

   task automatic checkOne(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic checkOutput(input string tag);
      checkOne({tag, " n2.pumps"},  8'(bus2.pumps),  m_pumps[0]);
      checkOne({tag, " n2.lead"},   8'(bus2.lead),   8'(m_lead[0]));
      checkOne({tag, " n2.demand"}, 8'(bus2.demand), 8'(m_demand[0]));
      checkOne({tag, " n2.state"},  8'(bus2.state),  8'(m_state[0]));
      checkOne({tag, " n2.fault"},  8'(bus2.fault),  8'(m_state[0] == 2));
      checkOne({tag, " n4.pumps"},  8'(bus4.pumps),  m_pumps[1]);
      checkOne({tag, " n4.lead"},   8'(bus4.lead),   8'(m_lead[1]));
      checkOne({tag, " n4.demand"}, 8'(bus4.demand), 8'(m_demand[1]));
      checkOne({tag, " n4.state"},  8'(bus4.state),  8'(m_state[1]));
      checkOne({tag, " n4.fault"},  8'(bus4.fault),  8'(m_state[1] == 2));
   endtask

   initial begin
      logic [1:0] a;
      logic [3:0] b;
      bit         r;
      int         k;

      bus2.sensors = '0;
      bus4.sensors = '0;
      $display("[TB] start");

      applyStimulus(2'b00, 4'b0000, 1'b1); checkOutput("reset");

      // Two-pump rotation then fault entry/exit with lead=1.
      applyStimulus(2'b01, 4'b0000, 1'b0); checkOutput("rot01");
      applyStimulus(2'b11, 4'b0000, 1'b0); checkOutput("rot11");
      applyStimulus(2'b01, 4'b0000, 1'b0); checkOutput("rot01b");
      for (int i = 0; i < MIN_ON + 1; i++) begin
         applyStimulus(2'b00, 4'b0000, 1'b0); checkOutput("rot00");
      end
      applyStimulus(2'b01, 4'b0000, 1'b0); checkOutput("rot_lead1");
      applyStimulus(2'b10, 4'b0000, 1'b0); checkOutput("fault_in");
      applyStimulus(2'b01, 4'b0000, 1'b0); checkOutput("fault_out");

      // Four-pump wrap: walk lead to 3, then demand two pumps.
      for (int n = 0; n < 3; n++) begin
         applyStimulus(2'b00, 4'b0001, 1'b0); checkOutput("walk_on");
         for (int i = 0; i < MIN_ON + 1; i++) begin
            applyStimulus(2'b00, 4'b0000, 1'b0); checkOutput("walk_off");
         end
      end
      applyStimulus(2'b00, 4'b0011, 1'b0); checkOutput("wrap0011");
      for (int i = 0; i < MIN_ON + 1; i++) begin
         applyStimulus(2'b00, 4'b0000, 1'b0); checkOutput("wrap0000");
      end

      // Reset in the middle of a run with sensors still asserted.
      applyStimulus(2'b11, 4'b0111, 1'b0); checkOutput("mid_run");
      applyStimulus(2'b11, 4'b0111, 1'b1); checkOutput("mid_reset");
      applyStimulus(2'b11, 4'b0111, 1'b0); checkOutput("post_reset");

      // Randomised traffic, mostly legal codes held for a few cycles.
      for (int n = 0; n < 400; n++) begin
         if ($urandom_range(0, 7) == 0) begin
            a = 2'($urandom);
         end else begin
            k = $urandom_range(0, 2);
            a = 2'((1 << k) - 1);
         end
         if ($urandom_range(0, 7) == 0) begin
            b = 4'($urandom);
         end else begin
            k = $urandom_range(0, 4);
            b = 4'((1 << k) - 1);
         end
         r = ($urandom_range(0, 49) == 0);
         for (int h = 0; h < $urandom_range(1, 3); h++) begin
            applyStimulus(a, b, r); checkOutput("random");
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end

endmodule
